// File: rtl/accum_avg_reader_pkg.sv
// Shared definitions for the sample-accumulation interface.
// Holds the block length agreed between the accumulator and this reader, the
// default datapath widths, and the reader FSM state encoding.
package accum_avg_reader_pkg;

  // Samples per accumulated block; the accumulator uses the same value.
  localparam int N_SAMPLES_DEF = 9;
  localparam int SUM_W_DEF     = 20;
  localparam int OUT_W_DEF     = 16;
  localparam int DROP_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider by a constant divisor, one quotient bit per
// cycle, MSB first.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-low reset
//   start_i    - load dividend_i, clear remainder/quotient/step counter
//   dividend_i - value to divide
//   last_o     - high during the cycle whose edge performs the final step
//   quot_o     - quotient (final once the last step has executed)
//   rem_o      - remainder (final once the last step has executed)
module seq_restoring_div
  import accum_avg_reader_pkg::*;
#(
  parameter int DIVIDEND_W = SUM_W_DEF,
  parameter int DIVISOR    = N_SAMPLES_DEF,
  localparam int REM_W     = $clog2(DIVISOR) + 1,
  localparam int CNT_W     = $clog2(DIVIDEND_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  output logic                  last_o,
  output logic [DIVIDEND_W-1:0] quot_o,
  output logic [REM_W-1:0]      rem_o
);

  localparam logic [REM_W-1:0] DIVISOR_V = REM_W'(DIVISOR);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIVIDEND_W - 1);

  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic [REM_W-1:0]      rem_shift_s;
  logic                  fits_s;

  // The remainder is always < DIVISOR, so its top bit is free to absorb the
  // shift without overflow.
  assign rem_shift_s = {rem_q[REM_W-2:0], dvd_q[DIVIDEND_W-1]};
  assign fits_s      = (rem_shift_s >= DIVISOR_V);

  // Next-state for one restoring-division step.
  always_comb begin
    dvd_d  = dvd_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (start_i) begin
      dvd_d  = dividend_i;
      quot_d = {DIVIDEND_W{1'b0}};
      rem_d  = {REM_W{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
      run_d  = 1'b1;
    end else if (run_q) begin
      dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
      if (fits_s) begin
        rem_d  = rem_shift_s - DIVISOR_V;
        quot_d = {quot_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift_s;
        quot_d = {quot_q[DIVIDEND_W-2:0], 1'b0};
      end
      if (cnt_q == LAST_CNT) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd_q  <= {DIVIDEND_W{1'b0}};
      quot_q <= {DIVIDEND_W{1'b0}};
      rem_q  <= {REM_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      run_q  <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign last_o = run_q && (cnt_q == LAST_CNT);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/accum_avg_reader.sv
// Consumer end of the sample-accumulation interface: divides each completed
// sum by N_SAMPLES, rounds to nearest, saturates to OUT_W bits and offers the
// result on a valid/ready port backed by a single output register.
// Ports:
//   clk, rst    - clock; synchronous active-low reset
//   sum_in      - completed accumulated sum
//   sum_valid   - one-cycle strobe qualifying sum_in
//   avg_out     - rounded average
//   avg_valid   - avg_out holds an unconsumed result
//   avg_ready   - downstream accepts when avg_valid & avg_ready
//   avg_sat     - avg_out was clipped to all-ones
//   busy        - divider pipeline not idle
//   drop_count  - sums discarded while busy (saturating)
module accum_avg_reader
  import accum_avg_reader_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int DROP_W    = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              sum_valid,
  output logic [OUT_W-1:0]  avg_out,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              avg_sat,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  localparam int REM_W = $clog2(N_SAMPLES) + 1;

  state_e            state_q, state_d;
  logic [OUT_W-1:0]  avg_out_q, avg_out_d;
  logic              avg_sat_q, avg_sat_d;
  logic              avg_valid_q, avg_valid_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              start_s;
  logic              div_last_s;
  logic [SUM_W-1:0]  quot_s;
  logic [REM_W-1:0]  rem_s;
  logic [REM_W:0]    rem2_s;
  logic              round_up_s;
  logic [SUM_W:0]    q_r_s;
  logic              sat_s;
  logic [OUT_W-1:0]  res_s;
  logic              out_free_s;
  logic              load_s;

  assign start_s = (state_q == ST_IDLE) && sum_valid;

  seq_restoring_div #(
    .DIVIDEND_W (SUM_W),
    .DIVISOR    (N_SAMPLES)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_s),
    .dividend_i (sum_in),
    .last_o     (div_last_s),
    .quot_o     (quot_s),
    .rem_o      (rem_s)
  );

  // Round half up: 2*rem >= N. One extra bit keeps 2*rem from wrapping.
  // The divider is not restarted while busy, so its outputs stay valid
  // through ROUND and HOLD and no separate holding register is needed.
  assign rem2_s     = {rem_s, 1'b0};
  assign round_up_s = (rem2_s >= (REM_W+1)'(N_SAMPLES));
  assign q_r_s      = {1'b0, quot_s} + {{SUM_W{1'b0}}, round_up_s};
  assign sat_s      = |q_r_s[SUM_W:OUT_W];
  assign res_s      = sat_s ? {OUT_W{1'b1}} : q_r_s[OUT_W-1:0];

  // Output register can take a new result if empty or drained this edge.
  assign out_free_s = !avg_valid_q || avg_ready;

  // FSM next-state and result-load decision.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sum_valid) begin
          state_d = ST_DIVIDE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        if (div_last_s) begin
          state_d = ST_ROUND;
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_ROUND, ST_HOLD: begin
        if (out_free_s) begin
          load_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register, busy flag and saturating drop counter.
  always_comb begin
    avg_out_d   = avg_out_q;
    avg_sat_d   = avg_sat_q;
    avg_valid_d = avg_valid_q;
    drop_d      = drop_q;
    busy_d      = (state_d != ST_IDLE);
    if (load_s) begin
      avg_out_d   = res_s;
      avg_sat_d   = sat_s;
      avg_valid_d = 1'b1;
    end else if (avg_valid_q && avg_ready) begin
      avg_valid_d = 1'b0;
    end else begin
      avg_valid_d = avg_valid_q;
    end
    if (sum_valid && (state_q != ST_IDLE) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      avg_out_q   <= {OUT_W{1'b0}};
      avg_sat_q   <= 1'b0;
      avg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= {DROP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      avg_out_q   <= avg_out_d;
      avg_sat_q   <= avg_sat_d;
      avg_valid_q <= avg_valid_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign avg_out    = avg_out_q;
  assign avg_sat    = avg_sat_q;
  assign avg_valid  = avg_valid_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_accum_avg_reader.sv
// Self-checking bench for accum_avg_reader (N_SAMPLES=9, 20-bit sums,
// 16-bit averages, 8-bit drop counter).
module tb_accum_avg_reader;

  logic        clk;
  logic        rst;
  logic [19:0] sum_in;
  logic        sum_valid;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic        avg_sat;
  logic        busy;
  logic [7:0]  drop_count;

  int checks;
  int errors;

  typedef struct {
    logic [19:0] sum;
    logic [15:0] avg;
    logic        sat;
  } vec_t;

  vec_t vecs[7];

  accum_avg_reader dut (
    .clk        (clk),
    .rst        (rst),
    .sum_in     (sum_in),
    .sum_valid  (sum_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .avg_sat    (avg_sat),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Strobe one sum; returns at the negedge after the sampling edge k.
  task automatic send(input logic [19:0] s);
    sum_in    = s;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  // Count edges after k until avg_valid, bounded.
  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!avg_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!avg_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got avg_valid=0 expected 1 within 60 cycles", name);
    end
  endtask

  initial begin
    int n;
    int extra;

    vecs[0] = '{sum: 20'd9000,   avg: 16'd1000,  sat: 1'b0};
    vecs[1] = '{sum: 20'd13,     avg: 16'd1,     sat: 1'b0};
    vecs[2] = '{sum: 20'd14,     avg: 16'd2,     sat: 1'b0};
    vecs[3] = '{sum: 20'd0,      avg: 16'd0,     sat: 1'b0};
    vecs[4] = '{sum: 20'd589815, avg: 16'd65535, sat: 1'b0};
    vecs[5] = '{sum: 20'hFFFFF,  avg: 16'd65535, sat: 1'b1};
    vecs[6] = '{sum: 20'd22,     avg: 16'd2,     sat: 1'b0};

    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    sum_in    = 20'd0;
    sum_valid = 1'b0;
    avg_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_avg_out", avg_out, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_sat", avg_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven nominal/rounding/saturation vectors, no backpressure.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sum);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_valid($sformatf("v%0d", i), n);
      chk($sformatf("v%0d_latency", i), n, 21);
      chk($sformatf("v%0d_avg", i), avg_out, vecs[i].avg);
      chk($sformatf("v%0d_sat", i), avg_sat, vecs[i].sat);
      @(negedge clk);
      chk($sformatf("v%0d_consumed", i), avg_valid, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end

    // Backpressure: first result parks in the output register, second in HOLD.
    avg_ready = 1'b0;
    send(20'd900);
    wait_valid("bp1", n);
    chk("bp1_avg", avg_out, 100);
    repeat (3) @(negedge clk);
    chk("bp1_stable_avg", avg_out, 100);
    chk("bp1_stable_valid", avg_valid, 1);
    send(20'd1800);
    repeat (25) @(negedge clk);
    chk("bp2_hold_busy", busy, 1);
    chk("bp2_hold_avg", avg_out, 100);
    chk("bp2_hold_valid", avg_valid, 1);
    avg_ready = 1'b1;
    @(negedge clk);
    chk("bp2_avg", avg_out, 200);
    chk("bp2_valid", avg_valid, 1);
    chk("bp2_busy", busy, 0);
    @(negedge clk);
    chk("bp2_drained", avg_valid, 0);

    // Drops: strobes at k+5 and k+10 are discarded.
    send(20'd9000);
    repeat (4) @(negedge clk);
    send(20'd18);
    repeat (4) @(negedge clk);
    send(20'd27);
    wait_valid("drop", n);
    chk("drop_avg", avg_out, 1000);
    chk("drop_count2", drop_count, 2);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (avg_valid) extra++;
    end
    chk("drop_no_extra", extra, 0);

    // Drop counter saturation under a continuous strobe.
    sum_in    = 20'd9;
    sum_valid = 1'b1;
    repeat (300) @(negedge clk);
    sum_valid = 1'b0;
    chk("drop_sat", drop_count, 255);
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drop_sat_idle", busy, 0);

    // Reset in the middle of a divide.
    send(20'd9000);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_valid", avg_valid, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_avg", avg_out, 0);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (avg_valid) extra++;
    end
    chk("mid_rst_no_output", extra, 0);
    send(20'd18);
    wait_valid("post_rst", n);
    chk("post_rst_latency", n, 21);
    chk("post_rst_avg", avg_out, 2);
    chk("post_rst_sat", avg_sat, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
